// File: rtl/busio_pkg.sv
// Shared constants for the fetch/memory bus arbiter: FSM encoding, default widths
// and the all-ones byte-enable pattern driven on reads.
package busio_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;

  // Wide enough for data buses up to 512 bits; users slice the low strobe bits.
  localparam logic [63:0] READ_STROBE_ALL = '1;

endpackage

// File: rtl/busio_arbiter.sv
// Serialises fetch and memory-stage accesses onto one valid/ready bus, memory first.
// Issue 1 cycle after IDLE sees a request; ready strobe 1 cycle after ext_ready; ext_* held while stalled.
module busio_arbiter
  import busio_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_request,
  input  logic [ADDR_WIDTH-1:0]   fetch_address,
  output logic                    fetch_ready,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  input  logic                    mem_request,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH/8-1:0] mem_strobe,
  input  logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    ext_valid,
  input  logic                    ext_ready,
  output logic                    ext_write,
  output logic [ADDR_WIDTH-1:0]   ext_address,
  output logic [DATA_WIDTH/8-1:0] ext_strobe,
  output logic [DATA_WIDTH-1:0]   ext_write_data,
  input  logic [DATA_WIDTH-1:0]   ext_read_data
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [1:0] state;
  logic       mem_take;
  logic       fetch_take;
  logic       fetch_live;

  // A client whose completion strobe is high this cycle still shows the request
  // it just finished; its new request only appears next cycle.
  always_comb begin
    mem_take   = mem_request && !mem_ready;
    fetch_take = fetch_request && !fetch_ready;
    fetch_live = fetch_request && (fetch_address == ext_address);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      ext_valid      <= 1'b0;
      ext_write      <= 1'b0;
      ext_address    <= '0;
      ext_strobe     <= '0;
      ext_write_data <= '0;
      fetch_ready    <= 1'b0;
      fetch_data     <= '0;
      mem_ready      <= 1'b0;
      mem_read_data  <= '0;
    end else begin
      fetch_ready <= 1'b0;
      mem_ready   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_take) begin
            state          <= ST_MEM;
            ext_valid      <= 1'b1;
            ext_write      <= mem_write;
            ext_address    <= mem_address;
            ext_strobe     <= mem_write ? mem_strobe : READ_STROBE_ALL[STRB_WIDTH-1:0];
            ext_write_data <= mem_write_data;
          end else if (fetch_take) begin
            state          <= ST_FETCH;
            ext_valid      <= 1'b1;
            ext_write      <= 1'b0;
            ext_address    <= fetch_address;
            ext_strobe     <= READ_STROBE_ALL[STRB_WIDTH-1:0];
            ext_write_data <= '0;
          end
        end
        ST_FETCH: begin
          if (ext_ready) begin
            state     <= ST_IDLE;
            ext_valid <= 1'b0;
            // A redirected or withdrawn fetch is dropped and reissued from IDLE.
            if (fetch_live) begin
              fetch_data  <= ext_read_data;
              fetch_ready <= 1'b1;
            end
          end
        end
        ST_MEM: begin
          if (ext_ready) begin
            state     <= ST_IDLE;
            ext_valid <= 1'b0;
            if (mem_request) begin
              mem_read_data <= ext_read_data;
              mem_ready     <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          ext_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_busio_arbiter.sv
// Directed scenarios plus randomized concurrent clients against a transaction-level scoreboard.
module tb_busio_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;
  logic        ext_valid;
  logic        ext_ready;
  logic        ext_write;
  logic [31:0] ext_address;
  logic [3:0]  ext_strobe;
  logic [31:0] ext_write_data;
  logic [31:0] ext_read_data;

  logic        slave_auto = 1'b0;
  logic        auto_ready = 1'b0;
  logic [31:0] auto_data  = '0;
  logic        man_ready  = 1'b0;
  logic [31:0] man_data   = '0;

  assign ext_ready     = slave_auto ? auto_ready : man_ready;
  assign ext_read_data = slave_auto ? auto_data  : man_data;

  always #5 clk = ~clk;

  busio_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_strobe(mem_strobe), .mem_write_data(mem_write_data),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_write(ext_write),
    .ext_address(ext_address), .ext_strobe(ext_strobe),
    .ext_write_data(ext_write_data), .ext_read_data(ext_read_data)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } bus_t;

  // Fetch addresses live below 0x1000, data addresses at 0x2000 and above.
  bus_t        exp_fbus[$];
  bus_t        exp_mbus[$];
  logic [31:0] exp_fetch[$];
  logic [32:0] exp_mem[$];   // {is_load, read data}

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no event (nothing queued)", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  bus_t prev_bus;
  logic hold_prev = 1'b0;

  always @(negedge clk) begin
    bus_t cur;
    bus_t e;
    logic [31:0] fd;
    logic [32:0] md;
    cur = {ext_write, ext_address, ext_strobe, ext_write_data};
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (ext_valid && hold_prev)
        chk("ext_hold_stable", 128'(cur), 128'(prev_bus));
      if (ext_valid && ext_ready) begin
        if (ext_address < 32'h1000) begin
          if (exp_fbus.size() == 0) unexpected("fetch_bus_issue");
          else begin
            e = exp_fbus.pop_front();
            chk("fetch_bus_addr", 128'(ext_address), 128'(e.a));
            chk("fetch_bus_ctl", 128'({ext_write, ext_strobe}), 128'({1'b0, 4'hF}));
          end
        end else begin
          if (exp_mbus.size() == 0) unexpected("mem_bus_issue");
          else begin
            e = exp_mbus.pop_front();
            chk("mem_bus_addr", 128'(ext_address), 128'(e.a));
            chk("mem_bus_ctl", 128'({ext_write, ext_strobe}), 128'({e.w, e.s}));
            if (e.w) chk("mem_bus_wdata", 128'(ext_write_data), 128'(e.d));
          end
        end
      end
      if (fetch_ready || mem_ready)
        chk("ready_exclusive", 128'({fetch_ready, mem_ready}) & 128'(fetch_ready & mem_ready), 128'(0));
      if (fetch_ready) begin
        if (exp_fetch.size() == 0) unexpected("fetch_ready_pulse");
        else begin
          fd = exp_fetch.pop_front();
          chk("fetch_data", 128'(fetch_data), 128'(fd));
        end
      end
      if (mem_ready) begin
        if (exp_mem.size() == 0) unexpected("mem_ready_pulse");
        else begin
          md = exp_mem.pop_front();
          if (md[32]) chk("mem_read_data", 128'(mem_read_data), 128'(md[31:0]));
        end
      end
      hold_prev = ext_valid && !ext_ready;
      prev_bus  = cur;
    end
  end

  // Random-latency slave
  always @(posedge clk) begin
    #1;
    if (slave_auto) begin
      auto_ready = ext_valid && ($urandom_range(0, 1) == 1);
      auto_data  = auto_ready ? rd_fn(ext_address) : $urandom;
    end
  end

  task automatic fetch_client(input int n_txn);
    for (int n = 0; n < n_txn; n++) begin
      logic [31:0] a;
      int t;
      int gap;
      a = 32'($urandom_range(0, 1023)) << 2;
      fetch_address = a;
      fetch_request = 1'b1;
      exp_fbus.push_back({1'b0, a, 4'hF, 32'h0});
      exp_fetch.push_back(rd_fn(a));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!fetch_ready && t < 300);
      if (!fetch_ready) chk("fetch_timeout", 128'(0), 128'(1));
      cyc();
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        fetch_request = 1'b0;
        repeat (gap) cyc();
      end
    end
    fetch_request = 1'b0;
  endtask

  task automatic mem_client(input int n_txn);
    for (int n = 0; n < n_txn; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        w;
      int t;
      int gap;
      a = 32'h2000 + (32'($urandom_range(0, 1023)) << 2);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      w = 1'($urandom_range(0, 1));
      mem_address    = a;
      mem_write      = w;
      mem_strobe     = s;
      mem_write_data = d;
      mem_request    = 1'b1;
      exp_mbus.push_back({w, a, w ? s : 4'hF, d});
      exp_mem.push_back({!w, w ? 32'h0 : rd_fn(a)});
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!mem_ready && t < 300);
      if (!mem_ready) chk("mem_timeout", 128'(0), 128'(1));
      cyc();
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        mem_request = 1'b0;
        repeat (gap) cyc();
      end
    end
    mem_request = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    fetch_request = 1'b0; fetch_address = '0;
    mem_request = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_strobe = '0; mem_write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 128'({ext_valid, fetch_ready, mem_ready, ext_write, ext_strobe}), 128'(0));
    chk("reset_addr_data", {ext_address, ext_write_data, fetch_data, mem_read_data}, 128'(0));
    cyc();
    reset = 1'b1;
    cyc();

    // Lone fetch: minimum latency
    fetch_request = 1'b1; fetch_address = 32'h100;
    exp_fbus.push_back({1'b0, 32'h100, 4'hF, 32'h0});
    exp_fetch.push_back(32'h0000_0013);
    cyc();
    chk("lone_valid", 128'(ext_valid), 128'(1));
    chk("lone_addr", 128'(ext_address), 128'(32'h100));
    man_ready = 1'b1; man_data = 32'h0000_0013;
    cyc();
    man_ready = 1'b0; fetch_request = 1'b0;
    chk("lone_fetch_ready", 128'(fetch_ready), 128'(1));
    chk("lone_fetch_data", 128'(fetch_data), 128'(32'h13));
    cyc();
    chk("lone_pulse_once", 128'({fetch_ready, ext_valid}), 128'(0));

    // Priority: memory wins the tie; fetch follows the mem_ready pulse
    fetch_request = 1'b1; fetch_address = 32'h180;
    mem_request = 1'b1; mem_write = 1'b0; mem_address = 32'h2000; mem_strobe = 4'h0;
    exp_mbus.push_back({1'b0, 32'h2000, 4'hF, 32'h0});
    exp_mem.push_back({1'b1, 32'hA0A0_0001});
    exp_fbus.push_back({1'b0, 32'h180, 4'hF, 32'h0});
    exp_fetch.push_back(32'h0B0B_0002);
    cyc();
    chk("prio_mem_first", 128'({ext_valid, ext_address}), 128'({1'b1, 32'h2000}));
    man_ready = 1'b1; man_data = 32'hA0A0_0001;
    cyc();
    man_ready = 1'b0;
    chk("prio_mem_ready", 128'(mem_ready), 128'(1));
    chk("prio_fetch_waits", 128'({ext_valid, fetch_ready}), 128'(0));
    cyc();
    mem_request = 1'b0;
    chk("prio_fetch_next", 128'({ext_valid, ext_address}), 128'({1'b1, 32'h180}));
    man_ready = 1'b1; man_data = 32'h0B0B_0002;
    cyc();
    man_ready = 1'b0; fetch_request = 1'b0;
    chk("prio_fetch_ready", 128'(fetch_ready), 128'(1));
    cyc();

    // Store with five wait states
    mem_request = 1'b1; mem_write = 1'b1; mem_address = 32'h3004;
    mem_strobe = 4'b0011; mem_write_data = 32'hDEAD_BEEF;
    exp_mbus.push_back({1'b1, 32'h3004, 4'b0011, 32'hDEAD_BEEF});
    exp_mem.push_back({1'b0, 32'h0});
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wait_bus_stable", 128'({ext_valid, ext_write, ext_address, ext_strobe, ext_write_data}),
          128'({1'b1, 1'b1, 32'h3004, 4'b0011, 32'hDEAD_BEEF}));
      chk("wait_no_ready", 128'(mem_ready), 128'(0));
    end
    cyc();
    man_ready = 1'b1; man_data = 32'h5555_AAAA;
    cyc();
    man_ready = 1'b0;
    chk("wait_mem_ready", 128'(mem_ready), 128'(1));
    cyc();
    mem_request = 1'b0;
    chk("wait_pulse_once", 128'({mem_ready, ext_valid}), 128'(0));

    // Stale fetch: redirect while outstanding
    fetch_request = 1'b1; fetch_address = 32'h100;
    exp_fbus.push_back({1'b0, 32'h100, 4'hF, 32'h0});
    cyc();
    fetch_address = 32'h400;
    exp_fbus.push_back({1'b0, 32'h400, 4'hF, 32'h0});
    exp_fetch.push_back(32'h1234_5678);
    cyc();
    man_ready = 1'b1; man_data = 32'hBAD0_BAD0;
    cyc();
    man_ready = 1'b0;
    chk("stale_no_ready", 128'({fetch_ready, ext_valid}), 128'(0));
    cyc();
    chk("stale_reissue", 128'({ext_valid, ext_address}), 128'({1'b1, 32'h400}));
    man_ready = 1'b1; man_data = 32'h1234_5678;
    cyc();
    man_ready = 1'b0; fetch_request = 1'b0;
    chk("stale_ready_new", 128'(fetch_ready), 128'(1));
    cyc();

    // Trap drop: load withdrawn before completion
    mem_request = 1'b1; mem_write = 1'b0; mem_address = 32'h2100;
    exp_mbus.push_back({1'b0, 32'h2100, 4'hF, 32'h0});
    cyc();
    mem_request = 1'b0;
    cyc();
    man_ready = 1'b1; man_data = 32'hFEED_0000;
    cyc();
    man_ready = 1'b0;
    chk("trap_no_ready", 128'({mem_ready, ext_valid}), 128'(0));
    cyc();
    chk("trap_stays_idle", 128'({mem_ready, ext_valid}), 128'(0));

    // Reset in the middle of a memory transaction
    mem_request = 1'b1; mem_write = 1'b0; mem_address = 32'h2200;
    cyc();
    chk("rstmid_valid", 128'(ext_valid), 128'(1));
    reset = 1'b0;
    #1;
    chk("rstmid_async_clear", 128'({ext_valid, mem_ready, fetch_ready}), 128'(0));
    chk("rstmid_regs", {ext_address, ext_write_data, mem_read_data, 28'h0, ext_strobe}, 128'(0));
    cyc();
    mem_request = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rstmid_no_ready", 128'({ext_valid, mem_ready}), 128'(0));
    end

    // Randomized concurrent traffic
    slave_auto = 1'b1;
    fork
      fetch_client(60);
      mem_client(60);
    join
    repeat (10) cyc();
    chk("fetch_bus_drained", 128'(exp_fbus.size()), 128'(0));
    chk("mem_bus_drained", 128'(exp_mbus.size()), 128'(0));
    chk("fetch_data_drained", 128'(exp_fetch.size()), 128'(0));
    chk("mem_data_drained", 128'(exp_mem.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
